// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the load/store unit: memory op codes,
// FSM state encodings, big-endian lane offsets and op classification helpers.
package mips_lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_SW  = 3'b011,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101,
        OP_SB  = 3'b110,
        OP_SH  = 3'b111
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_DATA  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_RESP     = 3'd4
    } lsu_state_e;

    // Big-endian: offset 0 is the most significant byte of the word
    localparam logic [1:0] OFF_BYTE0 = 2'd0;
    localparam logic [1:0] OFF_BYTE1 = 2'd1;
    localparam logic [1:0] OFF_BYTE2 = 2'd2;
    localparam logic [1:0] OFF_BYTE3 = 2'd3;
    localparam logic [1:0] OFF_HALF0 = 2'd0;
    localparam logic [1:0] OFF_HALF1 = 2'd2;

    function automatic logic is_rmw(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

    function automatic logic is_half(input mem_op_e op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input mem_op_e op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_misaligned(input mem_op_e op,
                                           input logic [1:0] off);
        return (is_half(op) && off[0]) || (is_word(op) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Lane steering for the load/store unit: extracts and extends the load
// value from a memory word, and merges a sub-word store into it.
module lsu_byte_lane
    import mips_lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] store_word
);

    mem_op_e     op_e;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] byte_merged;
    logic [31:0] half_merged;

    assign op_e = mem_op_e'(op);

    always_comb begin
        sel_byte    = word[7:0];
        byte_merged = word;
        case (offset)
            OFF_BYTE0: begin
                sel_byte    = word[31:24];
                byte_merged = {store_data[7:0], word[23:0]};
            end
            OFF_BYTE1: begin
                sel_byte    = word[23:16];
                byte_merged = {word[31:24], store_data[7:0], word[15:0]};
            end
            OFF_BYTE2: begin
                sel_byte    = word[15:8];
                byte_merged = {word[31:16], store_data[7:0], word[7:0]};
            end
            OFF_BYTE3: begin
                sel_byte    = word[7:0];
                byte_merged = {word[31:8], store_data[7:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        sel_half    = word[31:16];
        half_merged = {store_data[15:0], word[15:0]};
        if (offset[1]) begin
            sel_half    = word[15:0];
            half_merged = {word[31:16], store_data[15:0]};
        end
    end

    always_comb begin
        load_value = word;
        store_word = word;
        case (op_e)
            OP_LB:  load_value = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU: load_value = {24'd0, sel_byte};
            OP_LH:  load_value = {{16{sel_half[15]}}, sel_half};
            OP_LHU: load_value = {16'd0, sel_half};
            OP_LW:  load_value = word;
            OP_SB:  store_word = byte_merged;
            OP_SH:  store_word = half_merged;
            OP_SW:  store_word = store_data;
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: drives a word-wide big-endian data memory with a
// 1-cycle registered read; sub-word stores are done by read-modify-write.
module load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  Request,
    input  logic [2:0]            MemOp,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           StoreData,
    output logic [31:0]           LoadData,
    output logic                  Done,
    output logic                  Busy,
    output logic                  Misaligned,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [31:0]           MemWriteData,
    input  logic [31:0]           MemReadData
);

    lsu_state_e  state;
    lsu_state_e  next_state;
    mem_op_e     req_op;
    mem_op_e     op_q;
    logic [1:0]  offset_q;
    logic [31:0] store_q;
    logic        req_mis;
    logic        accept;
    logic [31:0] load_value;
    logic [31:0] store_word;

    assign req_op  = mem_op_e'(MemOp);
    assign req_mis = is_misaligned(req_op, Address[1:0]);
    assign accept  = (state == ST_IDLE) && Request;

    lsu_byte_lane u_lane (
        .op         (op_q),
        .offset     (offset_q),
        .word       (MemReadData),
        .store_data (store_q),
        .load_value (load_value),
        .store_word (store_word)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (Request) begin
                    if (req_mis)             next_state = ST_RESP;
                    else if (req_op == OP_SW) next_state = ST_WR_ISSUE;
                    else                     next_state = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: next_state = ST_RD_DATA;
            ST_RD_DATA:  next_state = is_rmw(op_q) ? ST_WR_ISSUE : ST_RESP;
            ST_WR_ISSUE: next_state = ST_RESP;
            ST_RESP:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        MemRead  = (state == ST_RD_ISSUE);
        MemWrite = (state == ST_WR_ISSUE);
        Done     = (state == ST_RESP);
        Busy     = (state != ST_IDLE);
    end

    // Capture registers, write buffer and load result
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q         <= OP_LB;
            offset_q     <= 2'd0;
            store_q      <= 32'd0;
            LoadData     <= 32'd0;
            MemAddress   <= '0;
            MemWriteData <= 32'd0;
            Misaligned   <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= req_op;
                offset_q   <= Address[1:0];
                store_q    <= StoreData;
                Misaligned <= req_mis;
                MemAddress <= {Address[ADDR_WIDTH-1:2], 2'b00};
                if (req_op == OP_SW) MemWriteData <= StoreData;
            end
            if (state == ST_RD_DATA) begin
                if (is_rmw(op_q)) MemWriteData <= store_word;
                else              LoadData     <= load_value;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table driven through a scoreboard,
// plus reset-during-RMW and request-while-busy sequences.
module tb_load_store_unit;
    import mips_lsu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        Request = 1'b0;
    logic [2:0]  MemOp = 3'd0;
    logic [31:0] Address = 32'd0;
    logic [31:0] StoreData = 32'd0;
    logic [31:0] LoadData;
    logic        Done, Busy, Misaligned, MemRead, MemWrite;
    logic [31:0] MemAddress, MemWriteData, MemReadData;

    logic [31:0] mem [0:1023];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_idx = 10'd0;
    logic [31:0] pl_val = 32'd0;
    logic [31:0] rdata = 32'd0;

    always #5 clock = ~clock;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .Request(Request), .MemOp(MemOp),
        .Address(Address), .StoreData(StoreData), .LoadData(LoadData),
        .Done(Done), .Busy(Busy), .Misaligned(Misaligned),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddress(MemAddress),
        .MemWriteData(MemWriteData), .MemReadData(MemReadData)
    );

    always @(posedge clock) begin
        if (pl_we) mem[pl_idx] <= pl_val;
        else if (MemWrite) mem[MemAddress[11:2]] <= MemWriteData;
        if (MemRead) rdata <= mem[MemAddress[11:2]];
    end
    assign MemReadData = rdata;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] load;
        logic        mis;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] wdata;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] load;
        logic        mis;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] wdata;
        int          start;
        int          rd0;
        int          wr0;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[20];
    int          nchecks = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] last_wdata = 32'd0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clock);
        cyc++;
        if (!reset) begin
            if (MemRead && MemWrite) both_cnt++;
            if (MemRead) rd_cnt++;
            if (MemWrite) begin
                wr_cnt++;
                last_wdata = MemWriteData;
            end
            if (Done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    nchecks++;
                    nfail++;
                    $display("FAIL spurious_done: Done at cycle %0d with no request pending", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, ".lat"}, 32'(cyc - e.start), 32'(e.lat));
                    check({e.name, ".load"}, LoadData, e.load);
                    check({e.name, ".mis"}, {31'd0, Misaligned}, {31'd0, e.mis});
                    check({e.name, ".reads"}, 32'(rd_cnt - e.rd0), 32'(e.rd));
                    check({e.name, ".writes"}, 32'(wr_cnt - e.wr0), 32'(e.wr));
                    if (e.wr != 0) check({e.name, ".wdata"}, last_wdata, e.wdata);
                end
            end
        end
    endtask

    task automatic access(input vec_t v, input bit noise);
        exp_t e;
        e.name  = v.name;
        e.load  = v.load;
        e.mis   = v.mis;
        e.lat   = v.lat;
        e.rd    = v.rd;
        e.wr    = v.wr;
        e.wdata = v.wdata;
        e.start = cyc;
        e.rd0   = rd_cnt;
        e.wr0   = wr_cnt;
        sb.push_back(e);
        Request   = 1'b1;
        MemOp     = v.op;
        Address   = v.addr;
        StoreData = v.sd;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) begin
                Request = noise;
                if (noise) begin
                    MemOp     = OP_SW;
                    Address   = 32'h100;
                    StoreData = 32'hDEADBEEF;
                end
            end
            if (sb.size() == 0) break;
        end
        Request = 1'b0;
        if (sb.size() != 0) begin
            nchecks++;
            nfail++;
            $display("FAIL %s.timeout: no Done within 12 cycles", v.name);
            sb.delete();
        end
        tick();
    endtask

    initial begin
        vec_t v;
        int   wr0;
        int   d0;

        vecs[0]  = '{"lb_101",  OP_LB,  32'h101, 32'h0,        32'hFFFFFF99, 1'b0, 3, 1, 0, 32'h0};
        vecs[1]  = '{"lbu_103", OP_LBU, 32'h103, 32'h0,        32'h000000BB, 1'b0, 3, 1, 0, 32'h0};
        vecs[2]  = '{"lhu_102", OP_LHU, 32'h102, 32'h0,        32'h0000AABB, 1'b0, 3, 1, 0, 32'h0};
        vecs[3]  = '{"lh_100",  OP_LH,  32'h100, 32'h0,        32'hFFFF8899, 1'b0, 3, 1, 0, 32'h0};
        vecs[4]  = '{"lw_100",  OP_LW,  32'h100, 32'h0,        32'h8899AABB, 1'b0, 3, 1, 0, 32'h0};
        vecs[5]  = '{"sb_102",  OP_SB,  32'h102, 32'h12,       32'h8899AABB, 1'b0, 4, 1, 1, 32'h889912BB};
        vecs[6]  = '{"sh_100",  OP_SH,  32'h100, 32'hCAFE,     32'h8899AABB, 1'b0, 4, 1, 1, 32'hCAFE12BB};
        vecs[7]  = '{"lw_100b", OP_LW,  32'h100, 32'h0,        32'hCAFE12BB, 1'b0, 3, 1, 0, 32'h0};
        vecs[8]  = '{"sw_201",  OP_SW,  32'h201, 32'h55555555, 32'hCAFE12BB, 1'b1, 1, 0, 0, 32'h0};
        vecs[9]  = '{"lw_100c", OP_LW,  32'h100, 32'h0,        32'hCAFE12BB, 1'b0, 3, 1, 0, 32'h0};
        vecs[10] = '{"sw_104",  OP_SW,  32'h104, 32'h01020304, 32'hCAFE12BB, 1'b0, 2, 0, 1, 32'h01020304};
        vecs[11] = '{"lb_104",  OP_LB,  32'h104, 32'h0,        32'h00000001, 1'b0, 3, 1, 0, 32'h0};
        vecs[12] = '{"lh_105",  OP_LH,  32'h105, 32'h0,        32'h00000001, 1'b1, 1, 0, 0, 32'h0};
        vecs[13] = '{"lhu_106", OP_LHU, 32'h106, 32'h0,        32'h00000304, 1'b0, 3, 1, 0, 32'h0};
        vecs[14] = '{"lb_107",  OP_LB,  32'h107, 32'h0,        32'h00000004, 1'b0, 3, 1, 0, 32'h0};
        vecs[15] = '{"sb_107",  OP_SB,  32'h107, 32'hFFFFFF80, 32'h00000004, 1'b0, 4, 1, 1, 32'h01020380};
        vecs[16] = '{"lb_107b", OP_LB,  32'h107, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 0, 32'h0};
        vecs[17] = '{"lbu_107", OP_LBU, 32'h107, 32'h0,        32'h00000080, 1'b0, 3, 1, 0, 32'h0};
        vecs[18] = '{"lw_102",  OP_LW,  32'h102, 32'h0,        32'h00000080, 1'b1, 1, 0, 0, 32'h0};
        vecs[19] = '{"sh_103",  OP_SH,  32'h103, 32'h7777,     32'h00000080, 1'b1, 1, 0, 0, 32'h0};

        pl_we = 1'b1;
        pl_idx = 10'h40; pl_val = 32'h8899AABB; tick();
        pl_idx = 10'h41; pl_val = 32'h00000000; tick();
        pl_idx = 10'h42; pl_val = 32'h11223344; tick();
        pl_we = 1'b0;
        reset = 1'b0;
        tick();

        check("rst.LoadData", LoadData, 32'h0);
        check("rst.MemAddress", MemAddress, 32'h0);
        check("rst.MemWriteData", MemWriteData, 32'h0);
        check("rst.ctrl", {27'd0, Done, Busy, Misaligned, MemRead, MemWrite}, 32'h0);

        foreach (vecs[i]) access(vecs[i], 1'b0);
        check("mem_100", mem[10'h40], 32'hCAFE12BB);
        check("mem_104", mem[10'h41], 32'h01020380);

        // Reset lands in RD_DATA of an SH: the pending write must never happen
        wr0       = wr_cnt;
        Request   = 1'b1;
        MemOp     = OP_SH;
        Address   = 32'h108;
        StoreData = 32'hBEEF;
        tick();
        Request = 1'b0;
        tick();
        check("rmwrst.busy_before", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        tick();
        check("rmwrst.busy", {31'd0, Busy}, 32'd0);
        check("rmwrst.ctrl", {30'd0, MemRead, MemWrite}, 32'd0);
        check("rmwrst.load", LoadData, 32'h0);
        reset = 1'b0;
        repeat (4) tick();
        check("rmwrst.nowrite", 32'(wr_cnt - wr0), 32'd0);
        check("rmwrst.mem", mem[10'h42], 32'h11223344);
        v = '{"lw_108", OP_LW, 32'h108, 32'h0, 32'h11223344, 1'b0, 3, 1, 0, 32'h0};
        access(v, 1'b0);

        // Request held high with a store while busy must be ignored
        d0 = done_cnt;
        v  = '{"lw_busy", OP_LW, 32'h100, 32'h0, 32'hCAFE12BB, 1'b0, 3, 1, 0, 32'h0};
        access(v, 1'b1);
        repeat (5) tick();
        check("busy.dones", 32'(done_cnt - d0), 32'd1);
        check("busy.mem", mem[10'h40], 32'hCAFE12BB);
        check("never_rd_and_wr", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", nchecks - nfail, nchecks);
        $finish;
    end

endmodule
